id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core. Sits between the ID-stage opcode decoder and the EX stage.
- Captures the decoder's 12-bit control word together with the PC, operands, immediate and register addresses.
- Detects load-use hazards and inserts bubbles; honours flushes from branch/jump resolution and freezes from EX.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register address width
- CTR_W, 12, control word width; field map below fixed for 12
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ctrSignalsIn  in  CTR_W  control word from ID decoder
- validIn  in  1  IFID holds a real instruction
- pcIn  in  DATA_W  PC of ID instruction
- rs1DataIn, rs2DataIn  in  DATA_W  register file read data
- immIn  in  DATA_W  extended immediate
- rs1AddrIn, rs2AddrIn, rdAddrIn  in  REG_AW  ID register fields
- flushIn  in  1  EX redirect (taken blt/beq, jal, jalr); squash ID instruction
- exHoldIn  in  1  EX not ready; freeze this register
- ctrSignalsOut  out  CTR_W  registered control to EX/MEM/WB
- validOut  out  1  registered valid
- pcOut, rs1DataOut, rs2DataOut, immOut  out  DATA_W  registered payload
- rs1AddrOut, rs2AddrOut, rdAddrOut  out  REG_AW  registered addresses
- stallOut  out  1  combinational; hold PC and IFID this cycle
- bubbleCntOut  out  CNT_W  bubbles inserted since reset

Behaviour:
- Control word fields:
  - [11] RegWrite
  - [10:9] DataSel
  - [8] MemRead
  - [7] MemWrite
  - [6:4] AddrSel
  - [3:1] ALUOp
  - [0] ALUSel
- Reset: asserting rst clears all registered outputs and bubbleCntOut to 0 immediately, regardless of clk. A mid-operation reset discards the in-flight instruction.
- Source usage, decoded from ctrSignalsIn:
  - rs1 is used unless DataSel==01 (lui) or (DataSel==11 and AddrSel==011) (jal).
  - rs2 is used when ALUSel==1 or MemWrite==1.
- Load-use hazard, combinational. Asserted when all of the following hold:
  - validOut && ctrSignalsOut[8] && rdAddrOut!=0 && validIn
  - and (rs1 used && rs1AddrIn==rdAddrOut) or (rs2 used && rs2AddrIn==rdAddrOut)
- stallOut = loadUse && !flushIn && !exHoldIn. An asserted exHoldIn already freezes upstream through the hazard unit, so stallOut is not raised on top of it.
- Per rising edge, first match wins:
  1. flushIn: load a bubble (validOut=0, ctrSignalsOut=0, payload don't-care but driven 0). flushIn beats exHoldIn.
  2. exHoldIn: hold all registers unchanged.
  3. loadUse: load a bubble. ID instruction stays in IFID and is reissued next cycle.
  4. Otherwise: load all inputs. When validIn==0, force ctrSignalsOut=0 and validOut=0.
- A bubble must never write registers or memory, so ctrSignalsOut is all zeros whenever validOut==0.
- Load-use costs exactly one bubble. After it, the load has left ID/EX and the hazard clears (EX/MEM forwarding is owned by EX).
- bubbleCntOut:
  - +1 on each edge taking branch 1 or 3.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Held during exHoldIn unless flushIn is also asserted.
- Latency: one cycle from inputs to outputs. No combinational path from inputs to registered outputs.

Test Plan:
- Reset: rst pulsed high between clock edges → all outputs 0 immediately, including ctrSignalsOut=12'h000 and bubbleCntOut=0.
- Pass-through: add, ctr=12'b100000000011, pc=0x10, rs1=3, rs2=4, rd=5, validIn=1 → next edge ctrSignalsOut=0x803, pcOut=0x10, rdAddrOut=5, stallOut=0.
- Load-use:
  - lw rd=7 (ctr 0xD02) captured, then add with rs2=7 in ID → stallOut=1 that cycle.
  - Next edge: validOut=0, ctr=0, bubbleCntOut=1.
  - Following edge: add captured, stallOut=0.
- No false stalls:
  - lw rd=0 followed by add rs1=0 → stallOut=0.
  - lw rd=7 followed by lui rd=2 with rs1 field=7 → stallOut=0.
- Flush vs hold:
  - flushIn=1 with exHoldIn=1 → bubble loaded, bubbleCntOut increments.
  - exHoldIn=1 alone for 3 cycles → outputs unchanged, counter unchanged.
- Saturation: preload bubbleCntOut to 0xFFFE via repeated flushes (force in bench), then 3 more flushes → counter stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage core.
// Captures the decoded control word and payload from ID, detects load-use
// hazards against the instruction currently in ID/EX, inserts bubbles on
// load-use or EX redirect, freezes on EX hold, and counts inserted bubbles.
//
// Control word fields:
//   [11] RegWrite  [10:9] DataSel  [8] MemRead  [7] MemWrite
//   [6:4] AddrSel  [3:1] ALUOp     [0] ALUSel
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTR_W  = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTR_W-1:0]  ctrSignalsIn,
  input  logic              validIn,
  input  logic [DATA_W-1:0] pcIn,
  input  logic [DATA_W-1:0] rs1DataIn,
  input  logic [DATA_W-1:0] rs2DataIn,
  input  logic [DATA_W-1:0] immIn,
  input  logic [REG_AW-1:0] rs1AddrIn,
  input  logic [REG_AW-1:0] rs2AddrIn,
  input  logic [REG_AW-1:0] rdAddrIn,
  input  logic              flushIn,
  input  logic              exHoldIn,
  output logic [CTR_W-1:0]  ctrSignalsOut,
  output logic              validOut,
  output logic [DATA_W-1:0] pcOut,
  output logic [DATA_W-1:0] rs1DataOut,
  output logic [DATA_W-1:0] rs2DataOut,
  output logic [DATA_W-1:0] immOut,
  output logic [REG_AW-1:0] rs1AddrOut,
  output logic [REG_AW-1:0] rs2AddrOut,
  output logic [REG_AW-1:0] rdAddrOut,
  output logic              stallOut,
  output logic [CNT_W-1:0]  bubbleCntOut
);

  // Control word bit positions
  localparam int MEM_READ_BIT  = 8;
  localparam int MEM_WRITE_BIT = 7;
  localparam int ALU_SEL_BIT   = 0;

  localparam logic [1:0] DATA_SEL_LUI = 2'b01;
  localparam logic [1:0] DATA_SEL_PC  = 2'b11;
  localparam logic [2:0] ADDR_SEL_JAL = 3'b011;

  // Everything held in the pipeline register
  typedef struct packed {
    logic [CTR_W-1:0]  ctr;
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
  } stage_t;

  stage_t           stage_d, stage_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [1:0]       data_sel;
  logic [2:0]       addr_sel;
  logic             rs1_used;
  logic             rs2_used;
  logic             load_use;
  logic             take_bubble;

  // Source-register usage of the ID instruction and load-use detection
  always_comb begin
    data_sel = ctrSignalsIn[10:9];
    addr_sel = ctrSignalsIn[6:4];
    // lui and jal do not read rs1; only R-type ALU ops and stores read rs2
    rs1_used = !((data_sel == DATA_SEL_LUI) ||
                 ((data_sel == DATA_SEL_PC) && (addr_sel == ADDR_SEL_JAL)));
    rs2_used = ctrSignalsIn[ALU_SEL_BIT] | ctrSignalsIn[MEM_WRITE_BIT];
    load_use = stage_q.valid && stage_q.ctr[MEM_READ_BIT] &&
               (stage_q.rd_addr != '0) && validIn &&
               ((rs1_used && (rs1AddrIn == stage_q.rd_addr)) ||
                (rs2_used && (rs2AddrIn == stage_q.rd_addr)));
  end

  // A held EX already freezes the front end, and a flush discards ID anyway
  assign stallOut = load_use && !flushIn && !exHoldIn;

  // Next-state selection: flush, then hold, then load-use bubble, then load
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    take_bubble  = 1'b0;
    if (flushIn) begin
      take_bubble = 1'b1;
    end else if (exHoldIn) begin
      stage_d = stage_q;
    end else if (load_use) begin
      take_bubble = 1'b1;
    end else begin
      stage_d.ctr      = ctrSignalsIn;
      stage_d.valid    = validIn;
      stage_d.pc       = pcIn;
      stage_d.rs1_data = rs1DataIn;
      stage_d.rs2_data = rs2DataIn;
      stage_d.imm      = immIn;
      stage_d.rs1_addr = rs1AddrIn;
      stage_d.rs2_addr = rs2AddrIn;
      stage_d.rd_addr  = rdAddrIn;
      // An empty slot must never write registers or memory downstream
      if (!validIn) begin
        stage_d.ctr   = '0;
        stage_d.valid = 1'b0;
      end
    end
    if (take_bubble) begin
      stage_d = '0;
      // Saturate rather than wrap so the monitor never under-reports
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ctrSignalsOut = stage_q.ctr;
  assign validOut      = stage_q.valid;
  assign pcOut         = stage_q.pc;
  assign rs1DataOut    = stage_q.rs1_data;
  assign rs2DataOut    = stage_q.rs2_data;
  assign immOut        = stage_q.imm;
  assign rs1AddrOut    = stage_q.rs1_addr;
  assign rs2AddrOut    = stage_q.rs2_addr;
  assign rdAddrOut     = stage_q.rd_addr;
  assign bubbleCntOut  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// A second instance with a 4-bit bubble counter shares the stimulus so that
// counter saturation is reached in a handful of cycles.
module tb_id_ex_stage;

  localparam logic [11:0] ADD = 12'h803;  // RegWrite, ALUOp=001, ALUSel=1
  localparam logic [11:0] LW  = 12'hD02;  // RegWrite, DataSel=10, MemRead, ALUOp=001
  localparam logic [11:0] LUI = 12'hA00;  // RegWrite, DataSel=01

  logic        clk;
  logic        rst;
  logic [11:0] ctrSignalsIn;
  logic        validIn;
  logic [31:0] pcIn, rs1DataIn, rs2DataIn, immIn;
  logic [4:0]  rs1AddrIn, rs2AddrIn, rdAddrIn;
  logic        flushIn, exHoldIn;

  logic [11:0] ctrSignalsOut;
  logic        validOut;
  logic [31:0] pcOut, rs1DataOut, rs2DataOut, immOut;
  logic [4:0]  rs1AddrOut, rs2AddrOut, rdAddrOut;
  logic        stallOut;
  logic [15:0] bubbleCntOut;

  logic [11:0] s_ctr;
  logic        s_valid;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
  logic        s_stall;
  logic [3:0]  s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ctrSignalsIn(ctrSignalsIn), .validIn(validIn), .pcIn(pcIn),
    .rs1DataIn(rs1DataIn), .rs2DataIn(rs2DataIn), .immIn(immIn),
    .rs1AddrIn(rs1AddrIn), .rs2AddrIn(rs2AddrIn), .rdAddrIn(rdAddrIn),
    .flushIn(flushIn), .exHoldIn(exHoldIn),
    .ctrSignalsOut(ctrSignalsOut), .validOut(validOut), .pcOut(pcOut),
    .rs1DataOut(rs1DataOut), .rs2DataOut(rs2DataOut), .immOut(immOut),
    .rs1AddrOut(rs1AddrOut), .rs2AddrOut(rs2AddrOut), .rdAddrOut(rdAddrOut),
    .stallOut(stallOut), .bubbleCntOut(bubbleCntOut)
  );

  id_ex_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .ctrSignalsIn(ctrSignalsIn), .validIn(validIn), .pcIn(pcIn),
    .rs1DataIn(rs1DataIn), .rs2DataIn(rs2DataIn), .immIn(immIn),
    .rs1AddrIn(rs1AddrIn), .rs2AddrIn(rs2AddrIn), .rdAddrIn(rdAddrIn),
    .flushIn(flushIn), .exHoldIn(exHoldIn),
    .ctrSignalsOut(s_ctr), .validOut(s_valid), .pcOut(s_pc),
    .rs1DataOut(s_rs1_data), .rs2DataOut(s_rs2_data), .immOut(s_imm),
    .rs1AddrOut(s_rs1_addr), .rs2AddrOut(s_rs2_addr), .rdAddrOut(s_rd_addr),
    .stallOut(s_stall), .bubbleCntOut(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present an instruction in ID; data fields derive from the addresses
  task automatic drive(input logic [11:0] ctr, input logic v, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
    ctrSignalsIn = ctr;
    validIn      = v;
    pcIn         = pc;
    rs1AddrIn    = a1;
    rs2AddrIn    = a2;
    rdAddrIn     = rd;
    rs1DataIn    = 32'h1000 + 32'(a1);
    rs2DataIn    = 32'h2000 + 32'(a2);
    immIn        = pc ^ 32'hFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flushIn = 1'b0;
    exHoldIn = 1'b0;
    drive(12'h000, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("reset_ctr", 32'(ctrSignalsOut), 32'h0);
    check("reset_valid", 32'(validOut), 32'h0);
    check("reset_cnt", 32'(bubbleCntOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through of an add
    drive(ADD, 1'b1, 32'h10, 5'd3, 5'd4, 5'd5);
    #1;
    check("pass_stall_pre", 32'(stallOut), 32'h0);
    tick();
    check("pass_ctr", 32'(ctrSignalsOut), 32'h803);
    check("pass_valid", 32'(validOut), 32'h1);
    check("pass_pc", pcOut, 32'h10);
    check("pass_rd", 32'(rdAddrOut), 32'h5);
    check("pass_rs1_data", rs1DataOut, 32'h1003);
    check("pass_imm", immOut, 32'hEF);
    check("pass_stall", 32'(stallOut), 32'h0);

    // Asynchronous reset pulse between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_ctr", 32'(ctrSignalsOut), 32'h0);
    check("arst_valid", 32'(validOut), 32'h0);
    check("arst_pc", pcOut, 32'h0);
    check("arst_rd", 32'(rdAddrOut), 32'h0);
    check("arst_cnt", 32'(bubbleCntOut), 32'h0);
    rst = 1'b0;

    // Load-use: lw x7, then add using rs2=x7
    @(negedge clk);
    drive(LW, 1'b1, 32'h20, 5'd1, 5'd0, 5'd7);
    tick();
    check("lw_ctr", 32'(ctrSignalsOut), 32'hD02);
    @(negedge clk);
    drive(ADD, 1'b1, 32'h24, 5'd2, 5'd7, 5'd8);
    #1;
    check("lu_stall", 32'(stallOut), 32'h1);
    tick();
    check("lu_bubble_valid", 32'(validOut), 32'h0);
    check("lu_bubble_ctr", 32'(ctrSignalsOut), 32'h0);
    check("lu_bubble_pc", pcOut, 32'h0);
    check("lu_cnt", 32'(bubbleCntOut), 32'h1);
    check("lu_stall_clear", 32'(stallOut), 32'h0);
    tick();
    check("lu_reissue_ctr", 32'(ctrSignalsOut), 32'h803);
    check("lu_reissue_pc", pcOut, 32'h24);
    check("lu_reissue_rd", 32'(rdAddrOut), 32'h8);
    check("lu_cnt_hold", 32'(bubbleCntOut), 32'h1);

    // No stall: lw x0 followed by add reading x0
    @(negedge clk);
    drive(LW, 1'b1, 32'h28, 5'd1, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(ADD, 1'b1, 32'h2C, 5'd0, 5'd0, 5'd9);
    #1;
    check("x0_stall", 32'(stallOut), 32'h0);
    tick();
    check("x0_rd", 32'(rdAddrOut), 32'h9);

    // No stall: lw x7 followed by lui whose rs1/rs2 fields happen to be 7
    @(negedge clk);
    drive(LW, 1'b1, 32'h30, 5'd1, 5'd0, 5'd7);
    tick();
    @(negedge clk);
    drive(LUI, 1'b1, 32'h34, 5'd7, 5'd7, 5'd2);
    #1;
    check("lui_stall", 32'(stallOut), 32'h0);
    tick();
    check("lui_ctr", 32'(ctrSignalsOut), 32'hA00);

    // Empty ID slot: control forced to zero, no bubble counted
    @(negedge clk);
    drive(ADD, 1'b0, 32'h38, 5'd1, 5'd2, 5'd3);
    tick();
    check("inv_ctr", 32'(ctrSignalsOut), 32'h0);
    check("inv_valid", 32'(validOut), 32'h0);
    check("inv_cnt", 32'(bubbleCntOut), 32'h1);

    // Flush wins over hold
    @(negedge clk);
    drive(ADD, 1'b1, 32'h40, 5'd1, 5'd2, 5'd10);
    tick();
    @(negedge clk);
    drive(ADD, 1'b1, 32'h44, 5'd1, 5'd2, 5'd11);
    flushIn = 1'b1;
    exHoldIn = 1'b1;
    tick();
    check("flush_valid", 32'(validOut), 32'h0);
    check("flush_ctr", 32'(ctrSignalsOut), 32'h0);
    check("flush_cnt", 32'(bubbleCntOut), 32'h2);

    // Hold for three cycles with a load-use pending: nothing moves
    @(negedge clk);
    flushIn = 1'b0;
    exHoldIn = 1'b0;
    drive(LW, 1'b1, 32'h50, 5'd4, 5'd0, 5'd11);
    tick();
    @(negedge clk);
    exHoldIn = 1'b1;
    drive(ADD, 1'b1, 32'h60, 5'd11, 5'd3, 5'd12);
    #1;
    check("hold_stall", 32'(stallOut), 32'h0);
    tick();
    tick();
    tick();
    check("hold_ctr", 32'(ctrSignalsOut), 32'hD02);
    check("hold_pc", pcOut, 32'h50);
    check("hold_rd", 32'(rdAddrOut), 32'hB);
    check("hold_rs1_data", rs1DataOut, 32'h1004);
    check("hold_cnt", 32'(bubbleCntOut), 32'h2);

    // Releasing the hold exposes the load-use
    @(negedge clk);
    exHoldIn = 1'b0;
    #1;
    check("release_stall", 32'(stallOut), 32'h1);
    tick();
    check("release_valid", 32'(validOut), 32'h0);
    check("release_cnt", 32'(bubbleCntOut), 32'h3);

    // Saturation: 12 flushes bring the 4-bit counter to 15, 3 more keep it there
    @(negedge clk);
    flushIn = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("sat_small_max", 32'(s_bubble_cnt), 32'hF);
    check("sat_main_15", 32'(bubbleCntOut), 32'hF);
    for (int i = 0; i < 3; i++) tick();
    check("sat_small_hold", 32'(s_bubble_cnt), 32'hF);
    check("sat_main_18", 32'(bubbleCntOut), 32'h12);
    check("sat_valid", 32'(validOut), 32'h0);
    flushIn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
